// File: rtl/spi_master_xfer_ctrl.sv
// SPI mode-0 master transfer sequencer: one DATA_WIDTH word out on MOSI (MSB first)
// while MISO is captured, with the SCK half-period latched from spi_bitrate at acceptance.
module spi_master_xfer_ctrl #(
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  clk_cpu,
   input  logic                  rst,
   input  logic [31:0]           spi_bitrate,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] tx_data,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  CS_n,
   output logic                  SCK,
   output logic                  MOSI,
   input  logic                  MISO
);

   localparam int unsigned      TGL_W    = $clog2(2 * DATA_WIDTH + 1);
   localparam logic [TGL_W-1:0] LAST_TGL = TGL_W'(2 * DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARM,
      ST_SETUP,
      ST_SHIFT,
      ST_HOLD
   } state_t;

   state_t                state_q, state_d;
   logic [31:0]           n_q, n_d;
   logic [31:0]           cnt_q, cnt_d;
   logic [TGL_W-1:0]      tgl_q, tgl_d;
   logic [DATA_WIDTH-1:0] tx_sr_q, tx_sr_d;
   logic [DATA_WIDTH-1:0] rx_sr_q, rx_sr_d;
   logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  cs_n_q, cs_n_d;
   logic                  sck_q, sck_d;
   logic                  mosi_q, mosi_d;
   logic                  hp_end;
   logic                  accept;

   assign hp_end = (cnt_q == n_q - 32'd1);

   // ARM is a one-cycle pre-select state; accepting on the final HOLD edge lets a
   // held start chain transfers with CS_n high for a single cycle.
   assign accept = start && ((state_q == ST_IDLE) || ((state_q == ST_HOLD) && hp_end));

   always_comb begin
      state_d   = state_q;
      n_d       = n_q;
      cnt_d     = cnt_q;
      tgl_d     = tgl_q;
      tx_sr_d   = tx_sr_q;
      rx_sr_d   = rx_sr_q;
      rx_data_d = rx_data_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      cs_n_d    = cs_n_q;
      sck_d     = sck_q;
      mosi_d    = mosi_q;

      case (state_q)
         ST_IDLE: begin
         end
         ST_ARM: begin
            state_d = ST_SETUP;
            cs_n_d  = 1'b0;
            mosi_d  = tx_sr_q[DATA_WIDTH-1];
            cnt_d   = '0;
            tgl_d   = '0;
         end
         ST_SETUP, ST_SHIFT: begin
            if (hp_end) begin
               cnt_d = '0;
               tgl_d = tgl_q + 1'b1;
               sck_d = ~sck_q;
               if (!sck_q) begin
                  rx_sr_d = {rx_sr_q[DATA_WIDTH-2:0], MISO};
                  state_d = ST_SHIFT;
               end else if (tgl_q == LAST_TGL) begin
                  state_d = ST_HOLD;
               end else begin
                  tx_sr_d = tx_sr_q << 1;
                  mosi_d  = tx_sr_q[DATA_WIDTH-2];
               end
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         ST_HOLD: begin
            if (hp_end) begin
               state_d   = ST_IDLE;
               done_d    = 1'b1;
               busy_d    = 1'b0;
               cs_n_d    = 1'b1;
               mosi_d    = 1'b0;
               rx_data_d = rx_sr_q;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (accept) begin
         state_d = ST_ARM;
         busy_d  = 1'b1;
         n_d     = (spi_bitrate == '0) ? 32'd1 : spi_bitrate;
         tx_sr_d = tx_data;
         rx_sr_d = '0;
         cnt_d   = '0;
      end
   end

   always_ff @(posedge clk_cpu) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         n_q       <= '0;
         cnt_q     <= '0;
         tgl_q     <= '0;
         tx_sr_q   <= '0;
         rx_sr_q   <= '0;
         rx_data_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         cs_n_q    <= 1'b1;
         sck_q     <= 1'b0;
         mosi_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         n_q       <= n_d;
         cnt_q     <= cnt_d;
         tgl_q     <= tgl_d;
         tx_sr_q   <= tx_sr_d;
         rx_sr_q   <= rx_sr_d;
         rx_data_q <= rx_data_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         cs_n_q    <= cs_n_d;
         sck_q     <= sck_d;
         mosi_q    <= mosi_d;
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign rx_data = rx_data_q;
   assign CS_n    = cs_n_q;
   assign SCK     = sck_q;
   assign MOSI    = mosi_q;

endmodule

// File: tb/tb_spi_master_xfer_ctrl.sv
// Bench for spi_master_xfer_ctrl: closed-form timing model compared every cycle,
// directed scenarios with literal expectations, then a randomized run.
module tb_spi_master_xfer_ctrl;

   localparam int W = 8;

   logic          clk_cpu = 1'b0;
   logic          rst = 1'b1;
   logic [31:0]   spi_bitrate = 32'd1;
   logic          start = 1'b0;
   logic [W-1:0]  tx_data = '0;
   logic          busy, done, CS_n, SCK, MOSI, MISO;
   logic [W-1:0]  rx_data;

   spi_master_xfer_ctrl #(.DATA_WIDTH(W)) dut (
      .clk_cpu    (clk_cpu),
      .rst        (rst),
      .spi_bitrate(spi_bitrate),
      .start      (start),
      .tx_data    (tx_data),
      .busy       (busy),
      .done       (done),
      .rx_data    (rx_data),
      .CS_n       (CS_n),
      .SCK        (SCK),
      .MOSI       (MOSI),
      .MISO       (MISO)
   );

   always #5 clk_cpu = ~clk_cpu;

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // MISO source: 0 random, 1 loopback, 2 tied high, 3 mode-0 slave shifting slave_word
   int           miso_mode  = 0;
   logic         miso_drv   = 1'b0;
   logic [W-1:0] slave_word = '0;
   assign MISO = (miso_mode == 1) ? MOSI : miso_drv;

   initial begin : slave_proc
      int   idx;
      logic prev_sck;
      idx = 0;
      prev_sck = 1'b0;
      forever begin
         @(posedge clk_cpu);
         #2;
         if (CS_n) idx = 0;
         else if (prev_sck && !SCK && idx < W - 1) idx++;
         prev_sck = SCK;
         case (miso_mode)
            0:       miso_drv = 1'($urandom_range(0, 1));
            2:       miso_drv = 1'b1;
            3:       miso_drv = slave_word[W-1-idx];
            default: miso_drv = 1'b0;
         endcase
      end
   end

   // Reference model: each transfer is described by its acceptance edge k, N and tx;
   // every output is a closed-form function of the offset from k.
   int           cyc = 0;
   bit           m_seen_rst = 0;
   bit           m_active = 0;
   bit           m_done = 0;
   longint       m_k = 0;
   longint       m_n = 1;
   logic [W-1:0] m_tx = '0;
   logic [W-1:0] m_acc = '0;
   logic [W-1:0] m_rxd = '0;

   int           done_cnt = 0;
   int           rise_cnt = 0;
   int           cs_low_cnt = 0;
   int           hi_run = 0;
   int           last_hi_run = 0;
   logic [W-1:0] mosi_rise = '0;

   initial begin : model_proc
      logic         s_rst, s_start, s_miso, prev_sck;
      logic [W-1:0] s_tx;
      logic [31:0]  s_br;
      longint       o, t;
      int           b;
      logic         e_cs, e_sck, e_mosi;
      prev_sck = 1'b0;
      forever begin
         @(posedge clk_cpu);
         cyc++;
         s_rst = rst; s_start = start; s_tx = tx_data; s_br = spi_bitrate; s_miso = MISO;
         if (s_rst) begin
            m_seen_rst = 1;
            m_active = 0;
            m_done = 0;
            m_rxd = '0;
         end else begin
            m_done = 0;
            if (m_active) begin
               o = longint'(cyc) - m_k;
               if (o > 1 && (o - 1) % m_n == 0) begin
                  t = (o - 1) / m_n;
                  if (t % 2 == 1 && t < 2 * W) m_acc = {m_acc[W-2:0], s_miso};
               end
               if (o == 1 + (2 * W + 1) * m_n) begin
                  m_rxd = m_acc;
                  m_done = 1;
                  m_active = 0;
               end
            end
            if (!m_active && s_start) begin
               m_active = 1;
               m_k = cyc;
               m_n = (s_br == 0) ? 1 : longint'(s_br);
               m_tx = s_tx;
               m_acc = '0;
            end
         end

         @(negedge clk_cpu);
         if (m_seen_rst) begin
            e_cs = 1'b1; e_sck = 1'b0; e_mosi = 1'b0;
            if (m_active) begin
               o = longint'(cyc) - m_k;
               if (o > 0) begin
                  t = (o - 1) / m_n;
                  b = int'(t / 2);
                  if (b > W - 1) b = W - 1;
                  e_cs = 1'b0;
                  e_sck = (t % 2 == 1);
                  e_mosi = m_tx[W-1-b];
               end
            end
            chk("busy", busy, m_active);
            chk("done", done, m_done);
            chk("rx_data", rx_data, m_rxd);
            chk("CS_n", CS_n, e_cs);
            chk("SCK", SCK, e_sck);
            chk("MOSI", MOSI, e_mosi);
         end
         if (done) done_cnt++;
         if (SCK && !prev_sck) begin
            rise_cnt++;
            mosi_rise = {mosi_rise[W-2:0], MOSI};
         end
         prev_sck = SCK;
         if (!CS_n) cs_low_cnt++;
         if (CS_n) hi_run++;
         else begin
            if (hi_run > 0) last_hi_run = hi_run;
            hi_run = 0;
         end
      end
   end

   task automatic tick();
      @(posedge clk_cpu);
      #1;
   endtask

   task automatic wait_done(input string name, input int limit,
                            output longint d_edge, output logic [W-1:0] rx);
      bit seen;
      seen = 0;
      d_edge = -1;
      rx = '0;
      for (int i = 0; i < limit && !seen; i++) begin
         tick();
         if (done) begin
            seen = 1;
            d_edge = cyc;
            rx = rx_data;
         end
      end
      chk({name, "_done_seen"}, seen, 1);
   endtask

   task automatic launch(input logic [W-1:0] tx, input logic [31:0] br, output longint s_edge);
      tx_data = tx;
      spi_bitrate = br;
      start = 1'b1;
      s_edge = cyc + 1;
      tick();
      start = 1'b0;
   endtask

   initial begin : stim
      longint       s_edge, d_edge, d1;
      logic [W-1:0] rx, rx1;
      int           base_rise, base_low, base_done;
      logic [31:0]  brs [2];
      bit           hit;

      repeat (3) tick();
      rst = 1'b0;
      chk("reset_busy", busy, 0);
      chk("reset_cs_n", CS_n, 1);
      chk("reset_sck", SCK, 0);
      chk("reset_rx", rx_data, 0);
      repeat (2) tick();

      // loopback, N=2
      miso_mode = 1;
      base_rise = rise_cnt; base_low = cs_low_cnt;
      launch(8'hA5, 32'd2, s_edge);
      wait_done("t1", 200, d_edge, rx);
      chk("t1_latency", d_edge - s_edge, 35);
      chk("t1_rx", rx, 8'hA5);
      chk("t1_sck_rises", rise_cnt - base_rise, 8);
      chk("t1_cs_low", cs_low_cnt - base_low, 34);
      repeat (3) tick();

      // bitrate 0 behaves as 1
      miso_mode = 2;
      brs[0] = 32'd0; brs[1] = 32'd1;
      for (int i = 0; i < 2; i++) begin
         base_rise = rise_cnt;
         launch(8'h3C, brs[i], s_edge);
         wait_done("t2", 100, d_edge, rx);
         chk("t2_latency", d_edge - s_edge, 18);
         chk("t2_rx", rx, 8'hFF);
         chk("t2_sck_rises", rise_cnt - base_rise, 8);
         repeat (2) tick();
      end

      // slave returns 0x5A
      miso_mode = 3;
      slave_word = 8'h5A;
      launch(8'h81, 32'd3, s_edge);
      wait_done("t3", 200, d_edge, rx);
      chk("t3_latency", d_edge - s_edge, 52);
      chk("t3_mosi_at_rise", mosi_rise, 8'h81);
      chk("t3_rx", rx, 8'h5A);
      repeat (2) tick();

      // start and bitrate disturbed mid-transfer
      miso_mode = 1;
      base_done = done_cnt;
      launch(8'h96, 32'd3, s_edge);
      repeat (15) tick();
      tx_data = 8'hFF;
      spi_bitrate = 32'd7;
      start = 1'b1;
      repeat (3) tick();
      start = 1'b0;
      wait_done("t4", 200, d_edge, rx);
      chk("t4_latency", d_edge - s_edge, 52);
      chk("t4_rx", rx, 8'h96);
      repeat (60) tick();
      chk("t4_done_count", done_cnt - base_done, 1);

      // reset after the 3rd SCK rise
      base_rise = rise_cnt;
      launch(8'hC3, 32'd2, s_edge);
      hit = 0;
      for (int i = 0; i < 100 && !hit; i++) begin
         tick();
         if (rise_cnt - base_rise >= 3) hit = 1;
      end
      chk("t5_third_rise_seen", hit, 1);
      base_done = done_cnt;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t5_cs_n", CS_n, 1);
      chk("t5_sck", SCK, 0);
      chk("t5_busy", busy, 0);
      chk("t5_rx", rx_data, 0);
      repeat (60) tick();
      chk("t5_no_done", done_cnt - base_done, 0);
      launch(8'h5E, 32'd2, s_edge);
      wait_done("t5b", 200, d_edge, rx);
      chk("t5b_latency", d_edge - s_edge, 35);
      chk("t5b_rx", rx, 8'h5E);
      repeat (2) tick();

      // back-to-back with start held high
      tx_data = 8'h6D;
      spi_bitrate = 32'd1;
      start = 1'b1;
      s_edge = cyc + 1;
      tick();
      tx_data = 8'hB2;
      wait_done("t6a", 100, d1, rx1);
      start = 1'b0;
      chk("t6a_latency", d1 - s_edge, 18);
      chk("t6a_rx", rx1, 8'h6D);
      wait_done("t6b", 100, d_edge, rx);
      chk("t6b_latency", d_edge - d1, 18);
      chk("t6b_rx", rx, 8'hB2);
      chk("t6_cs_high_gap", last_hi_run, 1);
      repeat (3) tick();

      // randomized traffic
      miso_mode = 0;
      for (int i = 0; i < 4000; i++) begin
         start = ($urandom_range(0, 7) == 0);
         tx_data = W'($urandom);
         if ($urandom_range(0, 15) == 0) spi_bitrate = 32'($urandom_range(0, 3));
         rst = ($urandom_range(0, 599) == 0);
         tick();
      end
      rst = 1'b0;
      start = 1'b0;
      repeat (80) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
